truth_table_sweep: RTL and testbench
====================================

# truth_table_sweep

Sequential stimulus-and-capture stage wrapped around a 3-input truth-table gate module. It drives `in1`/`in2`/`in3` through all eight input rows in order 000→111, waits a programmable settle time per row to model propagation delay, samples the gate's `out`, and assembles the measured 8-bit truth table in the same hex notation used for gate names. It then compares the measured table against an expected value. It sits directly upstream of the gate (feeds its inputs) and downstream of it (consumes its output).

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: cycles each row is held before sampling; legal range 0..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a sweep; honoured only in IDLE or DONE.
- `expected` in 8: expected table, captured on the accepted `start` edge.
- `out_sample` in 1: gate output under test.
- `in1`, `in2`, `in3` out 1 each: registered gate inputs; `{in1,in2,in3}` is the row index.
- `busy` out 1: high while sweeping.
- `done` out 1: one-cycle pulse when a sweep completes.
- `table` out 8: measured truth table; held until the next accepted `start`.
- `match` out 1: `table == expected_q`; valid from `done` onward, held.
- `mismatch_mask` out 8: `table ^ expected_q`; valid and held like `match`.

## Operation
- FSM states and transitions:
  - IDLE → SETTLE on `start`.
  - SETTLE → SAMPLE when the settle count reaches `SETTLE_CYCLES`, or immediately if it is 0.
  - SAMPLE → SETTLE with row+1 if row < 7.
  - SAMPLE → DONE if row == 7.
  - DONE → IDLE, or DONE → SETTLE if `start` is high.
- Bit mapping: the row r result is written to `table[7-r]`, so row 000 is the MSB. Sweeping a gate that outputs 1 for rows 000–011 yields `8'hF0`.
- On an accepted `start`:
  - `expected_q` ← `expected`.
  - `table`, `match`, `mismatch_mask` ← 0.
  - row ← 0.
- `in1..in3` change only on a row advance or on `start`. They are held stable through SETTLE and SAMPLE.
- In SAMPLE, `out_sample` is registered into `table[7-row]` at the end of the cycle.
- `match` and `mismatch_mask` are registered in the cycle that enters DONE and use the final table.
- `start` while `busy` is ignored. It is neither queued nor used to restart.
- Reset values (also when `rst` is asserted mid-sweep):
  - `in1..in3` = 0, `busy` = 0, `done` = 0.
  - `table` = 0, `match` = 0, `mismatch_mask` = 0.
  - state = IDLE, settle counter = 0, `expected_q` = 0.
- `rst` has priority over `start` in the same cycle.

## Timing
- Let the accepted `start` be sampled at edge 0, and S = `SETTLE_CYCLES`.
- Each row occupies S+1 cycles: S settle cycles, then 1 SAMPLE cycle.
- Row r is driven during cycles 1 + r(S+1) through (r+1)(S+1). Its sample edge is the end of cycle (r+1)(S+1).
- `busy` is high in cycles 1 .. 8(S+1).
- `done` is high only in cycle 8(S+1)+1. `busy` is low in that cycle.
- With S = 4: rows take 5 cycles each, `busy` covers cycles 1–40, and `done` fires at cycle 41.
- With S = 0: each row is 1 cycle (SAMPLE only), `busy` covers cycles 1–8, and `done` fires at cycle 9.
- A `start` in the DONE cycle re-arms with no gap: cycle 8(S+1)+2 drives row 0 of the new sweep.
- Row wrap: after row 7 the row counter does not advance. `in1..in3` hold 111 until the next `start` or `rst`.

## Structure
- Package `tt_pkg` contains:
  - state enum `tt_state_t` {IDLE, SETTLE, SAMPLE, DONE};
  - constants `TT_INPUTS = 3` and `TT_ROWS = 8`;
  - function `row_bit(row)` returning 7-row.
- Sub-module `settle_timer`:
  - loadable down-counter;
  - ports `clk`, `rst`, `load`, `expired`;
  - parameterised by `SETTLE_CYCLES`.
- The top level holds the FSM, row counter, input registers, table shift/write, and compare logic.

## Test plan
- **Expected match, S = 4.** Loop back a model of the 1111_0000 gate (`out = ~in1`). Pulse `start` with `expected = 8'hF0`. Required: `done` at cycle 41, `table = 8'hF0`, `match = 1`, `mismatch_mask = 0`.
- **Expected mismatch.** Same gate, `expected = 8'hF1`. Required: `table = 8'hF0`, `match = 0`, `mismatch_mask = 8'h01`.
- **Stimulus ordering, S = 0.** Gate model is AND3. Required: rows 000..111 appear on consecutive cycles 1–8, `table = 8'h01`, `done` at cycle 9.
- **`start` while busy.** Pulse `start` again at cycle 10 with a different `expected`. Required: the sweep is unaffected, `done` still fires at cycle 41, and the original `expected` is used.
- **Reset mid-sweep.** Assert `rst` at cycle 17. Required next cycle: all outputs 0 and state IDLE. A following `start` produces a full, correct sweep.
- **Back-to-back sweeps.** Hold `start` high in the DONE cycle. Required:
  - row 0 is driven in the cycle after `done`;
  - `table` is cleared to 0;
  - the second `done` arrives exactly 8(S+1)+1 cycles after the first.

Source files
------------

// File: rtl/truth_table_sweep_pkg.sv
// Shared types and constants for the truth-table sweep stage: the sweep
// FSM state encoding, the gate geometry and the row-to-bit mapping.
package tt_pkg;

    // Sweep controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_t;

    // Number of gate inputs and the number of rows in its truth table.
    localparam int TT_INPUTS = 3;
    localparam int TT_ROWS   = 8;

    // Index of the last row; the sweep stops advancing once it gets here.
    localparam logic [TT_INPUTS-1:0] TT_LAST_ROW = TT_INPUTS'(TT_ROWS - 1);

    // Row 000 lands in the MSB so the table reads like the gate's hex name.
    function automatic logic [TT_INPUTS-1:0] row_bit(input logic [TT_INPUTS-1:0] row);
        return TT_LAST_ROW - row;
    endfunction

endpackage

// File: rtl/truth_table_sweep_if.sv
// Bundle of the control handshake and the gate stimulus/response signals.
// The master side requests sweeps and closes the loop through the gate;
// the slave side is the sweep stage itself.
interface truth_table_sweep_if;
    import tt_pkg::*;

    logic                 start;
    logic [TT_ROWS-1:0]   expected;
    logic                 out_sample;
    logic                 in1;
    logic                 in2;
    logic                 in3;
    logic                 busy;
    logic                 done;
    logic [TT_ROWS-1:0]   meas_table;
    logic                 match;
    logic [TT_ROWS-1:0]   mismatch_mask;

    modport master (
        output start,
        output expected,
        output out_sample,
        input  in1,
        input  in2,
        input  in3,
        input  busy,
        input  done,
        input  meas_table,
        input  match,
        input  mismatch_mask
    );

    modport slave (
        input  start,
        input  expected,
        input  out_sample,
        output in1,
        output in2,
        output in3,
        output busy,
        output done,
        output meas_table,
        output match,
        output mismatch_mask
    );

endinterface

// File: rtl/truth_table_sweep_settle_timer.sv
// Loadable down-counter that marks the last settle cycle of a row.
// Loading SETTLE_CYCLES on entry to SETTLE makes expired rise in the
// SETTLE_CYCLES-th settle cycle, so the controller moves to SAMPLE next.
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Reload on request, otherwise count down and rest at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = 8'(SETTLE_CYCLES);
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q <= 8'd1);

endmodule

// File: rtl/truth_table_sweep.sv
// Truth-table sweep stage: walks a 3-input gate through rows 000..111,
// lets each row settle, samples the gate output into the measured table
// and compares the finished table against the expected one.
module truth_table_sweep
    import tt_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    truth_table_sweep_if.slave   bus
);

    // With no settle time a row is a single SAMPLE cycle, so SETTLE is skipped.
    localparam tt_state_t ROW_ENTRY = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    tt_state_t              state_q;
    tt_state_t              state_d;
    logic [TT_INPUTS-1:0]   row_q;
    logic [TT_INPUTS-1:0]   row_d;
    logic [TT_ROWS-1:0]     table_q;
    logic [TT_ROWS-1:0]     table_d;
    logic [TT_ROWS-1:0]     expected_q;
    logic [TT_ROWS-1:0]     expected_d;
    logic                   match_q;
    logic                   match_d;
    logic [TT_ROWS-1:0]     mask_q;
    logic [TT_ROWS-1:0]     mask_d;
    logic                   timer_load;
    logic                   timer_expired;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .expired (timer_expired)
    );

    // Next-state, row advance, table write and compare for the sweep FSM.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        table_d    = table_q;
        expected_d = expected_q;
        match_d    = match_q;
        mask_d     = mask_q;
        timer_load = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d    = ROW_ENTRY;
                    timer_load = 1'b1;
                    row_d      = '0;
                    table_d    = '0;
                    match_d    = 1'b0;
                    mask_d     = '0;
                    expected_d = bus.expected;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end

            SETTLE: begin
                if (timer_expired) begin
                    state_d = SAMPLE;
                end
            end

            SAMPLE: begin
                table_d[row_bit(row_q)] = bus.out_sample;
                if (row_q == TT_LAST_ROW) begin
                    state_d = DONE;
                    match_d = (table_d == expected_q);
                    mask_d  = table_d ^ expected_q;
                end else begin
                    row_d      = row_q + 1'b1;
                    state_d    = ROW_ENTRY;
                    timer_load = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, row, table and result registers; reset wins over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            table_q    <= '0;
            expected_q <= '0;
            match_q    <= 1'b0;
            mask_q     <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            table_q    <= table_d;
            expected_q <= expected_d;
            match_q    <= match_d;
            mask_q     <= mask_d;
        end
    end

    assign bus.in1           = row_q[2];
    assign bus.in2           = row_q[1];
    assign bus.in3           = row_q[0];
    assign bus.busy          = (state_q == SETTLE) || (state_q == SAMPLE);
    assign bus.done          = (state_q == DONE);
    assign bus.meas_table    = table_q;
    assign bus.match         = match_q;
    assign bus.mismatch_mask = mask_q;

endmodule

// File: tb/tb_truth_table_sweep.sv
// Bench for truth_table_sweep: a 4-cycle-settle instance swept through a
// table of gate models, a zero-settle instance for row ordering, and
// hand-written sequences for start-while-busy, mid-sweep reset and
// back-to-back sweeps.
module tb_truth_table_sweep;
    import tt_pkg::*;

    logic clk;
    logic rst;
    int   gate_sel;
    int   pass_cnt;
    int   total_cnt;

    truth_table_sweep_if if4 ();
    truth_table_sweep_if if0 ();

    truth_table_sweep #(.SETTLE_CYCLES(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    truth_table_sweep #(.SETTLE_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    // Gate models: 0 = ~in1 (F0), 1 = AND3 (01), 2 = XOR3 (69), 3 = MAJ3 (17).
    function automatic logic gate_fn(input int sel, input logic a, input logic b, input logic c);
        case (sel)
            0:       return ~a;
            1:       return a & b & c;
            2:       return a ^ b ^ c;
            3:       return (a & b) | (a & c) | (b & c);
            default: return 1'b0;
        endcase
    endfunction

    assign if4.out_sample = gate_fn(gate_sel, if4.in1, if4.in2, if4.in3);
    assign if0.out_sample = gate_fn(gate_sel, if0.in1, if0.in2, if0.in3);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         gate;
        logic [7:0] expected;
        logic [7:0] exp_table;
        logic       exp_match;
        logic [7:0] exp_mask;
    } vec_t;

    vec_t vecs [5];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Start a sweep on the S=4 instance and wait (bounded) for done.
    task automatic applyStimulus(input int gate, input logic [7:0] exp_val,
                                 input int poke_cycle, input logic [7:0] poke_exp,
                                 output int done_cyc);
        @(negedge clk);
        gate_sel     = gate;
        if4.expected = exp_val;
        if4.start    = 1'b1;
        @(posedge clk);
        #1;
        if4.start = 1'b0;
        done_cyc  = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == poke_cycle) begin
                if4.start    = 1'b1;
                if4.expected = poke_exp;
            end else begin
                if4.start = 1'b0;
            end
            if (if4.done) begin
                done_cyc = n;
                break;
            end
        end
        if4.start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int d1;
        int d2;
        pass_cnt     = 0;
        total_cnt    = 0;
        gate_sel     = 0;
        rst          = 1'b1;
        if4.start    = 1'b0;
        if4.expected = 8'h00;
        if0.start    = 1'b0;
        if0.expected = 8'h00;

        vecs[0] = '{gate: 0, expected: 8'hF0, exp_table: 8'hF0, exp_match: 1'b1, exp_mask: 8'h00};
        vecs[1] = '{gate: 0, expected: 8'hF1, exp_table: 8'hF0, exp_match: 1'b0, exp_mask: 8'h01};
        vecs[2] = '{gate: 2, expected: 8'h69, exp_table: 8'h69, exp_match: 1'b1, exp_mask: 8'h00};
        vecs[3] = '{gate: 3, expected: 8'h00, exp_table: 8'h17, exp_match: 1'b0, exp_mask: 8'h17};
        vecs[4] = '{gate: 1, expected: 8'h81, exp_table: 8'h01, exp_match: 1'b0, exp_mask: 8'h80};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_rows",  {29'd0, if4.in1, if4.in2, if4.in3}, 32'd0);
        checkOutput("reset_busy",  {31'd0, if4.busy}, 32'd0);
        checkOutput("reset_done",  {31'd0, if4.done}, 32'd0);
        checkOutput("reset_table", {24'd0, if4.meas_table}, 32'd0);
        checkOutput("reset_match", {31'd0, if4.match}, 32'd0);

        // Table-driven sweeps on the S=4 instance.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].gate, vecs[i].expected, 0, 8'h00, d1);
            checkOutput($sformatf("v%0d_done_cycle", i), d1, 32'd41);
            checkOutput($sformatf("v%0d_table", i), {24'd0, if4.meas_table}, {24'd0, vecs[i].exp_table});
            checkOutput($sformatf("v%0d_match", i), {31'd0, if4.match}, {31'd0, vecs[i].exp_match});
            checkOutput($sformatf("v%0d_mask", i), {24'd0, if4.mismatch_mask}, {24'd0, vecs[i].exp_mask});
        end

        // Start while busy, with a different expected value, is ignored.
        applyStimulus(0, 8'hF0, 10, 8'h0F, d1);
        checkOutput("busy_start_done_cycle", d1, 32'd41);
        checkOutput("busy_start_match", {31'd0, if4.match}, 32'd1);
        checkOutput("busy_start_mask", {24'd0, if4.mismatch_mask}, 32'd0);

        // Reset at cycle 17 of a sweep.
        @(negedge clk);
        gate_sel     = 0;
        if4.expected = 8'hF0;
        if4.start    = 1'b1;
        @(posedge clk);
        #1;
        if4.start = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_rows",  {29'd0, if4.in1, if4.in2, if4.in3}, 32'd0);
        checkOutput("midrst_busy",  {31'd0, if4.busy}, 32'd0);
        checkOutput("midrst_done",  {31'd0, if4.done}, 32'd0);
        checkOutput("midrst_table", {24'd0, if4.meas_table}, 32'd0);
        checkOutput("midrst_mask",  {24'd0, if4.mismatch_mask}, 32'd0);
        checkOutput("midrst_state", 32'(dut4.state_q), 32'(IDLE));
        applyStimulus(0, 8'hF0, 0, 8'h00, d1);
        checkOutput("postrst_done_cycle", d1, 32'd41);
        checkOutput("postrst_table", {24'd0, if4.meas_table}, 32'hF0);
        checkOutput("postrst_match", {31'd0, if4.match}, 32'd1);

        // Back-to-back: start held in the DONE cycle re-arms with no gap.
        applyStimulus(3, 8'h17, 0, 8'h00, d1);
        checkOutput("b2b_first_done", d1, 32'd41);
        if4.start = 1'b1;
        @(posedge clk);
        #1;
        if4.start = 1'b0;
        @(negedge clk);
        checkOutput("b2b_row0",  {29'd0, if4.in1, if4.in2, if4.in3}, 32'd0);
        checkOutput("b2b_busy",  {31'd0, if4.busy}, 32'd1);
        checkOutput("b2b_table", {24'd0, if4.meas_table}, 32'd0);
        d2 = -1;
        for (int n = 42; n <= 200; n++) begin
            if (if4.done) begin
                d2 = n;
                break;
            end
            @(negedge clk);
        end
        checkOutput("b2b_second_done", d2, 32'd82);
        checkOutput("b2b_table_final", {24'd0, if4.meas_table}, 32'h17);
        checkOutput("b2b_match", {31'd0, if4.match}, 32'd1);

        // Zero-settle instance: one row per cycle, AND3 gate.
        @(negedge clk);
        gate_sel     = 1;
        if0.expected = 8'h01;
        if0.start    = 1'b1;
        @(posedge clk);
        #1;
        if0.start = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            checkOutput($sformatf("s0_row_c%0d", n), {29'd0, if0.in1, if0.in2, if0.in3}, 32'(n - 1));
        end
        @(negedge clk);
        checkOutput("s0_done_c9", {31'd0, if0.done}, 32'd1);
        checkOutput("s0_busy_c9", {31'd0, if0.busy}, 32'd0);
        checkOutput("s0_table",   {24'd0, if0.meas_table}, 32'h01);
        checkOutput("s0_match",   {31'd0, if0.match}, 32'd1);
        @(negedge clk);
        checkOutput("s0_done_pulse", {31'd0, if0.done}, 32'd0);
        checkOutput("s0_row_hold",   {29'd0, if0.in1, if0.in2, if0.in3}, 32'd7);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
